// File: rtl/pipe_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_reg_pkg
// Shared definitions for the inter-stage pipeline register.
//   - Control bit indices within the ctrl field.
//   - Default widths used by the five-stage CPU datapath.
//   - pipe_slot_t: one slot's contents at the default widths.
// -----------------------------------------------------------------------------
package pipe_reg_pkg;

    // Control bit positions
    localparam int unsigned CTRL_MEMREAD  = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;
    localparam int unsigned CTRL_MEMWRITE = 2;
    localparam int unsigned CTRL_REGWRITE = 3;

    // Default widths
    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_CTRL_W = 4;
    localparam int unsigned DEF_WREG_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [DEF_CTRL_W-1:0] ctrl;
        logic [DEF_WREG_W-1:0] wreg;
        logic [DEF_DATA_W-1:0] data;
    } pipe_slot_t;

endpackage

// File: rtl/pipe_reg_slot.sv
// -----------------------------------------------------------------------------
// pipe_reg_slot
// One slot of the pipeline register chain: load, hold or bubble per edge.
// Priority: rst (async) > i_flush > i_stall (hold) > load.
// A load from an invalid source stores a clean bubble (all fields zero).
//
// Ports
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_stall                   hold current contents
//   i_flush                   become a bubble at the next edge
//   i_valid/i_data/i_ctrl/i_wreg   source contents
//   o_valid/o_data/o_ctrl/o_wreg   registered slot contents
// -----------------------------------------------------------------------------
module pipe_reg_slot #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned WREG_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [WREG_W-1:0] i_wreg,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [WREG_W-1:0] o_wreg
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;
    logic [WREG_W-1:0] r_wreg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
            r_wreg  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
            r_wreg  <= '0;
        end else if (!i_stall) begin
            // Invalid source: store zeros so downstream never sees stale fields
            r_valid <= i_valid;
            r_data  <= i_valid ? i_data : '0;
            r_ctrl  <= i_valid ? i_ctrl : '0;
            r_wreg  <= i_valid ? i_wreg : '0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;
    assign o_wreg  = r_wreg;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// DEPTH-deep chain of pipeline register slots with valid, global stall,
// per-slot flush and per-slot hazard taps. Outputs are straight from flops.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   stall                     every non-flushed slot holds
//   flush[DEPTH]              bit i turns slot i into a bubble
//   in_valid/in_data/in_ctrl/in_wreg      slot 0 source
//   out_valid/out_data/out_ctrl/out_wreg  contents of slot DEPTH-1
//   tap_valid[DEPTH]          valid of each slot
//   tap_wreg[DEPTH*WREG_W]    wreg of each slot, slot i at [i*WREG_W +: WREG_W]
//   tap_regwrite[DEPTH]       RegWrite gated by valid, per slot
//   stall_cnt, bubble_cnt     saturating performance counters
//
// Build option
//   PIPE_STAGE_REG_PERF_EN    when defined, the counters are implemented;
//                             otherwise both ports are tied to zero.
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_reg_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CTRL_W = DEF_CTRL_W,
    parameter int unsigned WREG_W = DEF_WREG_W,
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic [DEPTH-1:0]        flush,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [WREG_W-1:0]       in_wreg,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [WREG_W-1:0]       out_wreg,
    output logic [DEPTH-1:0]        tap_valid,
    output logic [DEPTH*WREG_W-1:0] tap_wreg,
    output logic [DEPTH-1:0]        tap_regwrite,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        bubble_cnt
);

    // Source of each slot and registered contents of each slot
    logic              w_src_valid [DEPTH];
    logic [DATA_W-1:0] w_src_data  [DEPTH];
    logic [CTRL_W-1:0] w_src_ctrl  [DEPTH];
    logic [WREG_W-1:0] w_src_wreg  [DEPTH];

    logic              w_q_valid   [DEPTH];
    logic [DATA_W-1:0] w_q_data    [DEPTH];
    logic [CTRL_W-1:0] w_q_ctrl    [DEPTH];
    logic [WREG_W-1:0] w_q_wreg    [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        if (g == 0) begin : g_head
            assign w_src_valid[g] = in_valid;
            assign w_src_data[g]  = in_data;
            assign w_src_ctrl[g]  = in_ctrl;
            assign w_src_wreg[g]  = in_wreg;
        end else begin : g_link
            // Upstream pre-edge contents, so a flushed slot still hands its
            // instruction to the next slot on the same edge
            assign w_src_valid[g] = w_q_valid[g-1];
            assign w_src_data[g]  = w_q_data[g-1];
            assign w_src_ctrl[g]  = w_q_ctrl[g-1];
            assign w_src_wreg[g]  = w_q_wreg[g-1];
        end

        pipe_reg_slot #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W),
            .WREG_W (WREG_W)
        ) u_slot (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_stall (stall),
            .i_flush (flush[g]),
            .i_valid (w_src_valid[g]),
            .i_data  (w_src_data[g]),
            .i_ctrl  (w_src_ctrl[g]),
            .i_wreg  (w_src_wreg[g]),
            .o_valid (w_q_valid[g]),
            .o_data  (w_q_data[g]),
            .o_ctrl  (w_q_ctrl[g]),
            .o_wreg  (w_q_wreg[g])
        );

        assign tap_valid[g]                   = w_q_valid[g];
        assign tap_wreg[g*WREG_W +: WREG_W]   = w_q_wreg[g];
        assign tap_regwrite[g]                = w_q_valid[g] & w_q_ctrl[g][CTRL_REGWRITE];
    end

    assign out_valid = w_q_valid[DEPTH-1];
    assign out_data  = w_q_data[DEPTH-1];
    assign out_ctrl  = w_q_ctrl[DEPTH-1];
    assign out_wreg  = w_q_wreg[DEPTH-1];

`ifdef PIPE_STAGE_REG_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_stall_inc;
    logic             w_bubble_inc;

    assign w_stall_inc  = stall & w_q_valid[DEPTH-1];
    // Last slot loads a zero valid: flushed, or advancing from a bubble
    assign w_bubble_inc = flush[DEPTH-1] | (~stall & ~w_src_valid[DEPTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_bubble_inc && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
    import pipe_reg_pkg::*;

`ifdef PIPE_STAGE_REG_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic [3:0]  in_ctrl = '0;
    logic [4:0]  in_wreg = '0;
    logic [0:0]  flush1 = '0;
    logic [1:0]  flush2 = '0;
    logic [2:0]  flush3 = '0;
    logic [0:0]  flush4 = '0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    // DEPTH=1
    logic        o1_valid;
    logic [63:0] o1_data;
    logic [3:0]  o1_ctrl;
    logic [4:0]  o1_wreg;
    logic [0:0]  o1_tapv, o1_taprw;
    logic [4:0]  o1_tapw;
    logic [15:0] o1_scnt, o1_bcnt;

    // DEPTH=2
    logic        o2_valid;
    logic [63:0] o2_data;
    logic [3:0]  o2_ctrl;
    logic [4:0]  o2_wreg;
    logic [1:0]  o2_tapv, o2_taprw;
    logic [9:0]  o2_tapw;
    logic [15:0] o2_scnt, o2_bcnt;

    // DEPTH=3
    logic        o3_valid;
    logic [63:0] o3_data;
    logic [3:0]  o3_ctrl;
    logic [4:0]  o3_wreg;
    logic [2:0]  o3_tapv, o3_taprw;
    logic [14:0] o3_tapw;
    logic [15:0] o3_scnt, o3_bcnt;

    // DEPTH=1, CNT_W=4
    logic        o4_valid;
    logic [63:0] o4_data;
    logic [3:0]  o4_ctrl;
    logic [4:0]  o4_wreg;
    logic [0:0]  o4_tapv, o4_taprw;
    logic [4:0]  o4_tapw;
    logic [3:0]  o4_scnt, o4_bcnt;

    pipe_stage_reg #(.DEPTH(1)) u1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush1),
        .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl), .in_wreg(in_wreg),
        .out_valid(o1_valid), .out_data(o1_data), .out_ctrl(o1_ctrl), .out_wreg(o1_wreg),
        .tap_valid(o1_tapv), .tap_wreg(o1_tapw), .tap_regwrite(o1_taprw),
        .stall_cnt(o1_scnt), .bubble_cnt(o1_bcnt));

    pipe_stage_reg #(.DEPTH(2)) u2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush2),
        .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl), .in_wreg(in_wreg),
        .out_valid(o2_valid), .out_data(o2_data), .out_ctrl(o2_ctrl), .out_wreg(o2_wreg),
        .tap_valid(o2_tapv), .tap_wreg(o2_tapw), .tap_regwrite(o2_taprw),
        .stall_cnt(o2_scnt), .bubble_cnt(o2_bcnt));

    pipe_stage_reg #(.DEPTH(3)) u3 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush3),
        .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl), .in_wreg(in_wreg),
        .out_valid(o3_valid), .out_data(o3_data), .out_ctrl(o3_ctrl), .out_wreg(o3_wreg),
        .tap_valid(o3_tapv), .tap_wreg(o3_tapw), .tap_regwrite(o3_taprw),
        .stall_cnt(o3_scnt), .bubble_cnt(o3_bcnt));

    pipe_stage_reg #(.DEPTH(1), .CNT_W(4)) u4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush4),
        .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl), .in_wreg(in_wreg),
        .out_valid(o4_valid), .out_data(o4_data), .out_ctrl(o4_ctrl), .out_wreg(o4_wreg),
        .tap_valid(o4_tapv), .tap_wreg(o4_tapw), .tap_regwrite(o4_taprw),
        .stall_cnt(o4_scnt), .bubble_cnt(o4_bcnt));

    // Stream vectors for the DEPTH=3 stall scenario (edge 1..10)
    int unsigned s_tag   [10] = '{1, 2, 3, 4, 4, 4, 5, 0, 0, 0};
    logic        s_stall [10] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    int unsigned s_out   [10] = '{0, 0, 1, 1, 1, 2, 3, 4, 5, 0};
    logic [2:0]  s_tapv  [10] = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b111,
                                  3'b111, 3'b111, 3'b110, 3'b100, 3'b000};

    // Advance one edge; return 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] w, input logic [3:0] c,
                         input logic [63:0] d);
        in_valid = v;
        in_wreg  = w;
        in_ctrl  = c;
        in_data  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        flush1 = '0; flush2 = '0; flush3 = '0; flush4 = '0;
        drive(1'b0, '0, '0, '0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 5'd9, 4'hF, 64'h1234);
        step();
        checks++;
        if (o1_valid !== 1'b0 || o1_data !== 64'd0 || o1_wreg !== 5'd0) begin
            errors++;
            $display("FAIL reset_u1: valid=%0b data=%0h wreg=%0d, expected 0", o1_valid, o1_data, o1_wreg);
        end
        checks++;
        if (o3_tapv !== 3'b000 || o3_tapw !== 15'd0 || o3_taprw !== 3'b000) begin
            errors++;
            $display("FAIL reset_u3_taps: tapv=%b tapw=%h taprw=%b, expected 0", o3_tapv, o3_tapw, o3_taprw);
        end
        checks++;
        if (o3_scnt !== 16'd0 || o3_bcnt !== 16'd0 || o4_scnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: scnt=%0d bcnt=%0d scnt4=%0d, expected 0", o3_scnt, o3_bcnt, o4_scnt);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b1, 5'd5, 4'b1001, 64'hDEADBEEF_00000004);
        #2;
        checks++;
        if (o1_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_no_comb: out_valid=%0b, expected 0", o1_valid);
        end
        step();
        checks++;
        if (o1_valid !== 1'b1 || o1_data !== 64'hDEADBEEF_00000004 ||
            o1_ctrl !== 4'b1001 || o1_wreg !== 5'd5) begin
            errors++;
            $display("FAIL single_out: valid=%0b data=%h ctrl=%b wreg=%0d, expected 1 deadbeef00000004 1001 5",
                     o1_valid, o1_data, o1_ctrl, o1_wreg);
        end
        checks++;
        if (o1_taprw !== 1'b1 || o1_tapv !== 1'b1 || o1_tapw !== 5'd5) begin
            errors++;
            $display("FAIL single_taps: taprw=%b tapv=%b tapw=%0d, expected 1 1 5", o1_taprw, o1_tapv, o1_tapw);
        end
        // Invalid input with junk fields stores a clean bubble
        drive(1'b0, 5'd31, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        checks++;
        if (o1_valid !== 1'b0 || o1_data !== 64'd0 || o1_ctrl !== 4'd0 ||
            o1_wreg !== 5'd0 || o1_taprw !== 1'b0) begin
            errors++;
            $display("FAIL single_bubble: valid=%0b data=%h ctrl=%b wreg=%0d, expected all 0",
                     o1_valid, o1_data, o1_ctrl, o1_wreg);
        end
    endtask

    task automatic test_stream_stall();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(s_tag[i] != 0, 5'(s_tag[i]), 4'b1000, 64'(s_tag[i]));
            stall = s_stall[i];
            step();
            checks++;
            if (o3_valid !== (s_out[i] != 0) || o3_wreg !== 5'(s_out[i]) ||
                o3_data !== 64'(s_out[i]) || o3_tapv !== s_tapv[i]) begin
                errors++;
                $display("FAIL stream_edge%0d: valid=%0b wreg=%0d data=%0h tapv=%b, expected tag %0d tapv=%b",
                         i + 1, o3_valid, o3_wreg, o3_data, o3_tapv, s_out[i], s_tapv[i]);
            end
        end
        stall = 1'b0;
        checks++;
        if (o3_scnt !== (PERF ? 16'd2 : 16'd0)) begin
            errors++;
            $display("FAIL stream_stall_cnt: got %0d expected %0d", o3_scnt, PERF ? 2 : 0);
        end
        checks++;
        if (o3_bcnt !== (PERF ? 16'd3 : 16'd0)) begin
            errors++;
            $display("FAIL stream_bubble_cnt: got %0d expected %0d", o3_bcnt, PERF ? 3 : 0);
        end
    endtask

    task automatic test_flush();
        pipe_slot_t exp_s;
        exp_s = '{valid: 1'b1, ctrl: 4'b1000, wreg: 5'd7, data: 64'd7};
        do_reset();
        drive(exp_s.valid, exp_s.wreg, exp_s.ctrl, exp_s.data);
        step();
        drive(1'b0, '0, '0, '0);
        flush2 = 2'b01;
        step();
        flush2 = 2'b00;
        checks++;
        if (o2_valid !== exp_s.valid || o2_wreg !== exp_s.wreg ||
            o2_ctrl !== exp_s.ctrl || o2_data !== exp_s.data) begin
            errors++;
            $display("FAIL flush_passes: valid=%0b wreg=%0d ctrl=%b data=%0h, expected 1 7 1000 7",
                     o2_valid, o2_wreg, o2_ctrl, o2_data);
        end
        checks++;
        if (o2_tapv !== 2'b10 || o2_tapw !== {5'd7, 5'd0} || o2_taprw !== 2'b10) begin
            errors++;
            $display("FAIL flush_slot0_bubble: tapv=%b tapw=%h taprw=%b, expected 10 0e0 10",
                     o2_tapv, o2_tapw, o2_taprw);
        end
        checks++;
        if (o2_bcnt !== (PERF ? 16'd1 : 16'd0)) begin
            errors++;
            $display("FAIL flush_bcnt_before: got %0d expected %0d", o2_bcnt, PERF ? 1 : 0);
        end
        step();
        checks++;
        if (o2_bcnt !== (PERF ? 16'd2 : 16'd0) || o2_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_bcnt_after: bcnt=%0d valid=%0b, expected %0d 0", o2_bcnt, o2_valid, PERF ? 2 : 0);
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        drive(1'b1, 5'd3, 4'b1000, 64'd3);
        step();
        drive(1'b1, 5'd4, 4'b1000, 64'd4);
        step();
        drive(1'b1, 5'd9, 4'b1000, 64'd9);
        stall = 1'b1;
        flush2 = 2'b10;
        step();
        checks++;
        if (o2_tapv !== 2'b01 || o2_tapw !== {5'd0, 5'd4} || o2_valid !== 1'b0 || o2_ctrl !== 4'd0) begin
            errors++;
            $display("FAIL stall_flush: tapv=%b tapw=%h valid=%0b ctrl=%b, expected 01 004 0 0",
                     o2_tapv, o2_tapw, o2_valid, o2_ctrl);
        end
        stall = 1'b0;
        flush2 = 2'b00;
        drive(1'b0, '0, '0, '0);
        step();
        checks++;
        if (o2_valid !== 1'b1 || o2_wreg !== 5'd4) begin
            errors++;
            $display("FAIL stall_flush_resume: valid=%0b wreg=%0d, expected 1 4", o2_valid, o2_wreg);
        end
        drive(1'b1, 5'd6, 4'b1000, 64'd6);
        step();
        stall = 1'b1;
        flush2 = 2'b11;
        step();
        stall = 1'b0;
        flush2 = 2'b00;
        drive(1'b0, '0, '0, '0);
        checks++;
        if (o2_tapv !== 2'b00 || o2_tapw !== 10'd0) begin
            errors++;
            $display("FAIL stall_flush_all: tapv=%b tapw=%h, expected 00 000", o2_tapv, o2_tapw);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 5'(i), 4'b1000, 64'(i));
            step();
        end
        checks++;
        if (o3_tapv !== 3'b111) begin
            errors++;
            $display("FAIL areset_fill: tapv=%b, expected 111", o3_tapv);
        end
        drive(1'b0, '0, '0, '0);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (o3_valid !== 1'b0 || o3_tapv !== 3'b000 || o3_tapw !== 15'd0 ||
            o3_data !== 64'd0 || o3_taprw !== 3'b000) begin
            errors++;
            $display("FAIL areset_immediate: valid=%0b tapv=%b tapw=%h data=%0h, expected all 0",
                     o3_valid, o3_tapv, o3_tapw, o3_data);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (o3_tapv !== 3'b000 || o3_valid !== 1'b0) begin
                errors++;
                $display("FAIL areset_no_replay%0d: tapv=%b valid=%0b, expected 000 0", i, o3_tapv, o3_valid);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        drive(1'b1, 5'd1, 4'b1000, 64'd1);
        step();
        stall = 1'b1;
        repeat (10) step();
        checks++;
        if (o4_scnt !== (PERF ? 4'd10 : 4'd0)) begin
            errors++;
            $display("FAIL sat_mid: got %0d expected %0d", o4_scnt, PERF ? 10 : 0);
        end
        repeat (5) step();
        checks++;
        if (o4_scnt !== (PERF ? 4'd15 : 4'd0)) begin
            errors++;
            $display("FAIL sat_max: got %0d expected %0d", o4_scnt, PERF ? 15 : 0);
        end
        repeat (5) step();
        checks++;
        if (o4_scnt !== (PERF ? 4'd15 : 4'd0) || o4_valid !== 1'b1 || o4_wreg !== 5'd1) begin
            errors++;
            $display("FAIL sat_hold: scnt=%0d valid=%0b wreg=%0d, expected %0d 1 1",
                     o4_scnt, o4_valid, o4_wreg, PERF ? 15 : 0);
        end
        stall = 1'b0;
        drive(1'b0, '0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream_stall();
        test_flush();
        test_stall_flush();
        test_async_reset();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage CPU. It generalises the fixed EX/MEM latch into a DEPTH-deep chain of identical slots, with a valid bit, global stall (hold), per-slot flush (bubble insertion) and per-slot hazard taps. It instantiates between any two stages (ID/EX, EX/MEM, MEM/WB) and carries the datapath words, the destination register index and the control bits.

## Interface
- DATA_W, 64: total datapath payload width, e.g. ALU result concatenated with store data.
- CTRL_W, 4: control bit count; bit indices are taken from the package.
- WREG_W, 5: destination register index width.
- DEPTH, 1: number of chained slots, 1..4.
- CNT_W, 16: width of the performance counters.
- clk  in  1: clock; all state updates on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- stall  in  1: when high, every slot holds its contents.
- flush  in  DEPTH: bit i turns slot i into a bubble at the next edge.
- in_valid  in  1: the incoming instruction is real.
- in_data  in  DATA_W: incoming payload.
- in_ctrl  in  CTRL_W: incoming control bits (MemRead, MemtoReg, MemWrite, RegWrite).
- in_wreg  in  WREG_W: incoming destination register.
- out_valid / out_data / out_ctrl / out_wreg  out: contents of slot DEPTH-1.
- tap_valid  out  DEPTH: valid bit of each slot.
- tap_wreg  out  DEPTH*WREG_W: destination register of each slot, with slot i at bits [i*WREG_W +: WREG_W].
- tap_regwrite  out  DEPTH: the effective RegWrite of each slot (ctrl RegWrite AND valid).
- stall_cnt, bubble_cnt  out  CNT_W: performance counters (see Configuration).

## Operation
- Slot 0 captures the in_* inputs. Slot i (i>0) captures slot i-1. Outputs come directly from the flops; there is no combinational path from input to output.
- Each slot's next state is decided per edge in this priority order:
  1. rst: the slot becomes a bubble.
  2. flush[i]: the slot becomes a bubble.
  3. stall: the slot holds its current contents.
  4. Otherwise the slot advances, loading from its source.
- Bubble means valid=0, ctrl=0, wreg=0, data=0. Data is zeroed so that waveforms and comparisons are deterministic.
- Slot 0 loading with in_valid=0 stores a bubble: ctrl, wreg and data are forced to 0 regardless of the inputs.
- flush overrides stall for the same slot. Non-flushed slots still hold under stall.
- If flush[i] is set and slot i+1 advances in the same cycle, slot i+1 receives slot i's pre-edge contents. Flush never kills data in flight to the downstream slot.
- Control bits are only meaningful when valid=1. Consumers must gate memory write and register write with the valid bit; tap_regwrite does this for the hazard unit.

## Timing
- Latency: DEPTH cycles from in_* to out_* when there is no stall or flush.
- Throughput: one instruction per cycle.
- Reset: all outputs, taps and counters go to 0 immediately on assertion of rst. The first capture happens on the first rising edge after deassertion.
- Reset mid-operation discards every in-flight instruction. Nothing is replayed.
- Stall held for N cycles: outputs are frozen for N cycles, then resume with no loss or duplication.
- stall together with all flush bits set: the whole chain empties in one edge.
- DEPTH=1 behaves like a classic single stage register with valid, stall and flush added.

## Configuration
- PIPE_STAGE_REG_PERF_EN defined:
  - stall_cnt increments on each edge where stall=1, rst=0 and out_valid=1.
  - bubble_cnt increments on each edge where out_valid would load 0, from either flush or an upstream bubble.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
  - Both counters clear on rst.
- PIPE_STAGE_REG_PERF_EN undefined:
  - Both ports stay present, tied to constant 0.
  - No counter flops are synthesised.

## Structure
- Shared package pipe_reg_pkg holds:
  - Control bit indices: CTRL_MEMREAD=0, CTRL_MEMTOREG=1, CTRL_MEMWRITE=2, CTRL_REGWRITE=3.
  - Default widths: DATA_W, CTRL_W, WREG_W.
  - A pipe_slot_t struct type {valid, ctrl, wreg, data}.
- One sub-module, pipe_reg_slot, holds a single slot with load, hold and bubble logic. The top level generates DEPTH instances of it, plus the counters and the tap flattening.

## Test plan
- Reset, then DEPTH=1: drive in_valid=1, data=0xDEADBEEF_00000004, ctrl=4'b1001, wreg=5 → exactly one cycle later out_* shows those values and tap_regwrite=1.
- DEPTH=3 with a stream of 5 instructions tagged 1..5 and stall held for 2 cycles mid-stream → outputs show 1..5 in order with no duplicates or gaps; with PERF enabled, stall_cnt=2.
- DEPTH=2 with flush=2'b01 while slot 0 holds wreg=7 → slot 1 still receives wreg=7; slot 0 becomes a bubble (ctrl=0, tap_valid[0]=0); bubble_cnt increments one cycle later.
- stall=1 and flush=2'b10 in the same cycle → slot 1 becomes a bubble and slot 0 holds its value.
- Assert rst asynchronously between clock edges while 3 slots are valid → all outputs are 0 before the next edge, and nothing reappears after release.
- PERF enabled with CNT_W=4 and stall held for 20 cycles with out_valid=1 → stall_cnt saturates at 15. With PERF disabled, stall_cnt stays at 0.
